// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler sharing one 1-bit channel (8:1 bit mux) among 8 requesters,
// with a per-grant transfer cap so a busy requester cannot starve the others.
module mux8_rr_scheduler #(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] din,
  input  logic       ready,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       dout,
  output logic       dout_valid,
  output logic       busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r, state_s;
  logic [7:0]       gnt_r, gnt_s;
  logic [2:0]       sel_r, sel_s;
  logic [2:0]       ptr_r, ptr_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             xfer_s;
  logic             release_s;
  logic [2:0]       pick_s;

  // First set bit of r scanning p, p+1, ... p+7 (mod 8).
  function automatic logic [2:0] rr_pick(input logic [2:0] p, input logic [7:0] r);
    logic [2:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign busy       = (state_r == GRANT);
  assign dout_valid = busy && req[sel_r];
  assign dout       = dout_valid & din[sel_r];
  assign gnt        = gnt_r;
  assign sel        = sel_r;

  // Next-state logic: arbitration, transfer counting and grant release.
  always_comb begin
    state_s   = state_r;
    gnt_s     = gnt_r;
    sel_s     = sel_r;
    ptr_s     = ptr_r;
    cnt_s     = cnt_r;
    xfer_s    = dout_valid && ready;
    release_s = 1'b0;
    pick_s    = 3'd0;
    case (state_r)
      IDLE: begin
        if (|req) begin
          pick_s  = rr_pick(ptr_r, req);
          state_s = GRANT;
          sel_s   = pick_s;
          gnt_s   = 8'b0000_0001 << pick_s;
          cnt_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        release_s = !req[sel_r] || (xfer_s && (cnt_r == CNT_LAST));
        if (release_s) begin
          // Scanning from sel+1 puts the releasing owner last in line.
          ptr_s = sel_r + 3'd1;
          cnt_s = '0;
          if (|req) begin
            pick_s  = rr_pick(sel_r + 3'd1, req);
            state_s = GRANT;
            sel_s   = pick_s;
            gnt_s   = 8'b0000_0001 << pick_s;
          end else begin
            state_s = IDLE;
            gnt_s   = 8'h00;
          end
        end else if (xfer_s) begin
          cnt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 8'h00;
        sel_s   = 3'd0;
        ptr_s   = 3'd0;
        cnt_s   = '0;
      end
    endcase
  end

  // State register with synchronous reset that drops any in-flight grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      gnt_r   <= 8'h00;
      sel_r   <= 3'd0;
      ptr_r   <= 3'd0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      sel_r   <= sel_s;
      ptr_r   <= ptr_s;
      cnt_r   <= cnt_s;
    end
  end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Directed self-checking bench for mux8_rr_scheduler (HOLD_MAX=4).
module tb_mux8_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] din = 8'h00;
  logic       ready = 1'b0;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       dout;
  logic       dout_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  mux8_rr_scheduler #(.HOLD_MAX(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .ready(ready),
    .gnt(gnt), .sel(sel), .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req = 8'hFF; ready = 1'b1; din = 8'h00; rst = 1'b1;
    step(); step();
    checks++;
    if (gnt !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: gnt=%h sel=%0d busy=%b dv=%b, want 00/0/0/0", gnt, sel, busy, dout_valid);
    end
    checks++;
    if (dut.ptr_r !== 3'd0 || dout !== 1'b0) begin
      errors++;
      $display("FAIL reset_ptr: ptr=%0d dout=%b, want 0/0", dut.ptr_r, dout);
    end
    rst = 1'b0;
    step();
    checks++;
    if (gnt !== 8'h01 || sel !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: gnt=%h sel=%0d busy=%b, want 01/0/1", gnt, sel, busy);
    end
  endtask

  task automatic test_fairness();
    logic exp_dout [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] g;
    req = 8'hFF; ready = 1'b1; din = 8'b1101_0101;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      g = 3'(k);
      for (int c = 0; c < 4; c++) begin
        step();
        checks++;
        if (sel !== g || gnt !== (8'h01 << g) || busy !== 1'b1) begin
          errors++;
          $display("FAIL rr_seq grant%0d cyc%0d: sel=%0d gnt=%h busy=%b, want sel=%0d", k, c, sel, gnt, busy, g);
        end
      end
      checks++;
      if (dout !== exp_dout[g] || dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_dout grant%0d: dout=%b dv=%b, want %b/1", k, dout, dout_valid, exp_dout[g]);
      end
    end
  endtask

  task automatic test_early_release_wrap();
    req = 8'b1000_0100; ready = 1'b1; din = 8'hFF;
    do_reset();
    step();
    checks++;
    if (sel !== 3'd2 || gnt !== 8'h04) begin
      errors++;
      $display("FAIL early_first: sel=%0d gnt=%h, want 2/04", sel, gnt);
    end
    step(); step();
    checks++;
    if (dut.cnt_r !== 4'd2) begin
      errors++;
      $display("FAIL early_cnt: cnt=%0d, want 2", dut.cnt_r);
    end
    req = 8'h80;
    #1;
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_dv_drop: dv=%b, want 0", dout_valid);
    end
    step();
    checks++;
    if (sel !== 3'd7 || gnt !== 8'h80 || busy !== 1'b1 || dut.cnt_r !== 4'd0) begin
      errors++;
      $display("FAIL early_to7: sel=%0d gnt=%h busy=%b cnt=%0d, want 7/80/1/0", sel, gnt, busy, dut.cnt_r);
    end
    req = 8'h04;
    step();
    checks++;
    if (sel !== 3'd2 || gnt !== 8'h04 || dut.ptr_r !== 3'd0) begin
      errors++;
      $display("FAIL wrap_to2: sel=%0d gnt=%h ptr=%0d, want 2/04/0", sel, gnt, dut.ptr_r);
    end
  endtask

  task automatic test_backpressure();
    int xfers;
    req = 8'h20; ready = 1'b0; din = 8'h20;
    do_reset();
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (sel !== 3'd5 || busy !== 1'b1 || dut.cnt_r !== 4'd0 || dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall cyc%0d: sel=%0d busy=%b cnt=%0d dv=%b, want 5/1/0/1", i, sel, busy, dut.cnt_r, dout_valid);
      end
    end
    ready = 1'b1;
    xfers = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (dout_valid && ready) xfers++;
      step();
      checks++;
      if (busy !== 1'b1 || sel !== 3'd5) begin
        errors++;
        $display("FAIL bp_nobubble cyc%0d: busy=%b sel=%0d, want 1/5", i, busy, sel);
      end
    end
    checks++;
    if (xfers !== 4 || dut.cnt_r !== 4'd0 || dut.ptr_r !== 3'd6 || gnt !== 8'h20) begin
      errors++;
      $display("FAIL bp_release: xfers=%0d cnt=%0d ptr=%0d gnt=%h, want 4/0/6/20", xfers, dut.cnt_r, dut.ptr_r, gnt);
    end
  endtask

  task automatic test_sole_idle();
    req = 8'h08; ready = 1'b1; din = 8'h08;
    do_reset();
    step(); step();
    checks++;
    if (sel !== 3'd3 || dout !== 1'b1 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL sole_grant: sel=%0d dout=%b dv=%b, want 3/1/1", sel, dout, dout_valid);
    end
    req = 8'h00;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || dout !== 1'b0) begin
      errors++;
      $display("FAIL sole_dv_drop: dv=%b dout=%b, want 0/0", dout_valid, dout);
    end
    step();
    checks++;
    if (gnt !== 8'h00 || busy !== 1'b0 || sel !== 3'd3 || dut.ptr_r !== 3'd4) begin
      errors++;
      $display("FAIL sole_idle: gnt=%h busy=%b sel=%0d ptr=%0d, want 00/0/3/4", gnt, busy, sel, dut.ptr_r);
    end
    step();
    checks++;
    if (busy !== 1'b0 || gnt !== 8'h00) begin
      errors++;
      $display("FAIL sole_stay_idle: busy=%b gnt=%h, want 0/00", busy, gnt);
    end
    req = 8'h01;
    step();
    checks++;
    if (sel !== 3'd0 || gnt !== 8'h01 || busy !== 1'b1) begin
      errors++;
      $display("FAIL sole_wrap_grant: sel=%0d gnt=%h busy=%b, want 0/01/1", sel, gnt, busy);
    end
  endtask

  task automatic test_reset_mid_grant();
    req = 8'h40; ready = 1'b0; din = 8'h41;
    do_reset();
    step();
    checks++;
    if (sel !== 3'd6 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rmg_pre: sel=%0d busy=%b, want 6/1", sel, busy);
    end
    rst = 1'b1; req = 8'h41;
    step();
    checks++;
    if (gnt !== 8'h00 || busy !== 1'b0 || dut.ptr_r !== 3'd0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmg_reset: gnt=%h busy=%b ptr=%0d dv=%b, want 00/0/0/0", gnt, busy, dut.ptr_r, dout_valid);
    end
    rst = 1'b0;
    step();
    checks++;
    if (sel !== 3'd0 || gnt !== 8'h01) begin
      errors++;
      $display("FAIL rmg_grant0: sel=%0d gnt=%h, want 0/01", sel, gnt);
    end
    ready = 1'b1;
    step(); step(); step(); step();
    checks++;
    if (sel !== 3'd6 || gnt !== 8'h40) begin
      errors++;
      $display("FAIL rmg_then6: sel=%0d gnt=%h, want 6/40", sel, gnt);
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_early_release_wrap();
    test_backpressure();
    test_sole_idle();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
